full_adder1: RTL and testbench
==============================

// Module: full_adder1
//
// PURPOSE
// - Gate-level full-adder cell: sum and carry of a + b + cin.
// - Leaf cell of the ripple-carry adder/subtractor. The parent chains one
//   instance per bit: carry -> next cin. For subtract, the parent XORs b
//   with ctrl and drives cin = 1.
// - Optional output pipeline registers (PIPE_STAGES) and a valid strobe.
//   With these, the cell can be retimed inside deeper datapaths.
//
// PARAMETERS
// - WIDTH        1  operand width. Per-bit gate full adders, internal ripple
//                   chain LSB to MSB.
// - PIPE_STAGES  0  output register stages, allowed 0..4.
//                   0 = purely combinational.
//
// PORTS
// - clk       in   1      rising-edge clock; unused when PIPE_STAGES = 0
// - rst_n     in   1      asynchronous, active-low reset
// - a         in   WIDTH  addend
// - b         in   WIDTH  addend (the parent pre-inverts it for subtract)
// - cin       in   1      carry in to the LSB
// - in_valid  in   1      qualifies a/b/cin
// - sum       out  WIDTH  sum bits
// - carry     out  1      carry out of the MSB
// - out_valid out  1      qualifies sum/carry
//
// BEHAVIOUR
// - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
// - Per bit i:
//   - s_i = a_i ^ b_i ^ c_i
//   - c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
//   - c_0 = cin; carry = c_WIDTH.
// - Build from xor/and/or primitives only; no behavioural '+'.
// - Arithmetic: {carry, sum} == a + b + cin, computed at WIDTH+1 bits with
//   no truncation. Wrap-around is visible only through carry:
//   a = b = all-ones, cin = 1 -> sum = all-ones, carry = 1.
// - PIPE_STAGES = 0:
//   - Outputs follow the inputs combinationally; out_valid = in_valid.
//   - clk and rst_n are ignored.
// - PIPE_STAGES = N > 0:
//   - The combinational result and in_valid pass through N register stages.
//   - Latency is exactly N cycles. Throughput is one result per cycle.
//   - No stall or backpressure. Every stage captures on every rising edge,
//     regardless of in_valid.
// - Reset:
//   - rst_n low immediately clears all stage registers.
//   - sum = 0, carry = 0, out_valid = 0 while reset is held.
//   - Reset asserted mid-operation flushes in-flight results; they never
//     appear.
//   - After rst_n rises, the first valid output appears N cycles after the
//     first sampled in_valid = 1.
// - Back-to-back inputs on consecutive cycles emerge in order, one per cycle.
// - X or Z on any input may propagate; no input sanitising.
//
// TESTING
// - Exhaustive, WIDTH=1, PIPE_STAGES=0: all 8 {a,b,cin}.
//   - 0,0,0 -> sum=0, carry=0
//   - 1,0,1 -> sum=0, carry=1
//   - 1,1,1 -> sum=1, carry=1
// - Chain of four WIDTH=1 cells, subtract mode (b inverted, cin=1):
//   - a=4, b=1 -> s=3, cout=1
//   - a=2, b=5 -> s=13, cout=0
// - WIDTH=4, PIPE_STAGES=0: a=15, b=15, cin=1 -> sum=15, carry=1.
//   Random sweep vs a+b+cin.
// - PIPE_STAGES=2: in_valid pulse with a=1, b=1, cin=0 at cycle k
//   -> sum=0, carry=1, out_valid=1 at cycle k+2 only.
// - PIPE_STAGES=2: rst_n low one cycle after that pulse
//   -> outputs 0 immediately; no out_valid ever appears for the pulse.
// - Streaming: 16 consecutive valid inputs -> 16 in-order results with no
//   gaps, matching the model.

Source files
------------

// File: rtl/full_adder1_if.sv
// full_adder1_if: operand/result bundle for the full_adder1 cell.
//   a, b      addends (WIDTH bits), cin carry into bit 0, in_valid qualifier
//   sum       result bits, carry out of the MSB, out_valid qualifier
//   master: producer of operands / consumer of results
//   slave : the adder cell itself
interface full_adder1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, carry, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, carry, out_valid
    );
endinterface

// File: rtl/full_adder1.sv
// full_adder1: gate-level ripple-carry adder cell with an optional output pipeline.
//   clk       rising-edge clock (only used when PIPE_STAGES > 0)
//   rst_n     asynchronous active-low reset, clears every stage register
//   bus       full_adder1_if.slave: a/b/cin/in_valid in, sum/carry/out_valid out
// {carry, sum} = a + b + cin. The result and in_valid are delayed by PIPE_STAGES
// cycles (0..4). There is no stall: each stage loads on every rising edge.
module full_adder1 #(
    parameter int WIDTH       = 1,
    parameter int PIPE_STAGES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder1_if.slave bus
);
    wire [WIDTH:0]   w_c;    // ripple carry, w_c[0] = cin
    wire [WIDTH-1:0] w_ab;   // a ^ b (propagate)
    wire [WIDTH-1:0] w_g;    // a & b (generate)
    wire [WIDTH-1:0] w_p;    // (a ^ b) & c_in
    wire [WIDTH-1:0] w_sum;

    assign w_c[0] = bus.cin;

    // One gate-level full adder per bit, LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor u_x0 (w_ab[i],  bus.a[i], bus.b[i]);
        xor u_x1 (w_sum[i], w_ab[i],  w_c[i]);
        and u_a0 (w_g[i],   bus.a[i], bus.b[i]);
        and u_a1 (w_p[i],   w_ab[i],  w_c[i]);
        or  u_o0 (w_c[i+1], w_g[i],   w_p[i]);
    end

    if (PIPE_STAGES == 0) begin : g_comb
        // Clock and reset have no function here; fold them into a sink.
        wire w_unused_ok = &{1'b0, clk, rst_n};

        assign bus.sum       = w_sum;
        assign bus.carry     = w_c[WIDTH];
        assign bus.out_valid = bus.in_valid;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0][WIDTH-1:0] r_sum_pipe;
        logic [PIPE_STAGES-1:0]            r_carry_pipe;
        logic [PIPE_STAGES-1:0]            r_vld_pipe;

        // Stage 0 captures the combinational result; later stages shift.
        // Reset clears every stage so in-flight results are dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum_pipe   <= '0;
                r_carry_pipe <= '0;
                r_vld_pipe   <= '0;
            end else begin
                r_sum_pipe[0]   <= w_sum;
                r_carry_pipe[0] <= w_c[WIDTH];
                r_vld_pipe[0]   <= bus.in_valid;
                for (int s = 1; s < PIPE_STAGES; s++) begin
                    r_sum_pipe[s]   <= r_sum_pipe[s-1];
                    r_carry_pipe[s] <= r_carry_pipe[s-1];
                    r_vld_pipe[s]   <= r_vld_pipe[s-1];
                end
            end
        end

        assign bus.sum       = r_sum_pipe[PIPE_STAGES-1];
        assign bus.carry     = r_carry_pipe[PIPE_STAGES-1];
        assign bus.out_valid = r_vld_pipe[PIPE_STAGES-1];
    end
endmodule

// File: tb/tb_full_adder1.sv
module tb_full_adder1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Expected {carry,sum} for {a,b,cin} = 0..7, worked by hand.
    localparam logic [1:0] EXP8 [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                                        2'b01, 2'b10, 2'b10, 2'b11};

    // WIDTH=1 combinational cell
    full_adder1_if #(.WIDTH(1)) if1 ();
    full_adder1 #(.WIDTH(1), .PIPE_STAGES(0)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // WIDTH=4 combinational cell
    full_adder1_if #(.WIDTH(4)) if4 ();
    full_adder1 #(.WIDTH(4), .PIPE_STAGES(0)) u_c4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    // WIDTH=1, two-stage pipeline
    full_adder1_if #(.WIDTH(1)) ifp1 ();
    full_adder1 #(.WIDTH(1), .PIPE_STAGES(2)) u_p1 (.clk(clk), .rst_n(rst_n), .bus(ifp1.slave));

    // WIDTH=4, two-stage pipeline for streaming
    full_adder1_if #(.WIDTH(4)) ifp4 ();
    full_adder1 #(.WIDTH(4), .PIPE_STAGES(2)) u_p4 (.clk(clk), .rst_n(rst_n), .bus(ifp4.slave));

    // Four chained WIDTH=1 cells in subtract mode: b inverted, cin=1
    logic [3:0] ch_a, ch_b;
    wire  [3:0] ch_s;
    wire  [4:0] ch_c;
    assign ch_c[0] = 1'b1;
    for (genvar k = 0; k < 4; k++) begin : g_ch
        full_adder1_if #(.WIDTH(1)) bus ();
        assign bus.a        = ch_a[k];
        assign bus.b        = ~ch_b[k];
        assign bus.cin      = ch_c[k];
        assign bus.in_valid = 1'b1;
        assign ch_s[k]      = bus.sum;
        assign ch_c[k+1]    = bus.carry;
        full_adder1 #(.WIDTH(1), .PIPE_STAGES(0)) u_fa (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0] sa [16];
    logic [3:0] sb [16];
    logic       sc [16];

    initial begin
        if1.a = '0;  if1.b = '0;  if1.cin = 0;  if1.in_valid = 0;
        if4.a = '0;  if4.b = '0;  if4.cin = 0;  if4.in_valid = 0;
        ifp1.a = '0; ifp1.b = '0; ifp1.cin = 0; ifp1.in_valid = 0;
        ifp4.a = '0; ifp4.b = '0; ifp4.cin = 0; ifp4.in_valid = 0;
        ch_a = '0;   ch_b = '0;

        // Reset state of the pipelined cells
        #12;
        chk("rst_p1", {30'd0, ifp1.out_valid, ifp1.carry}, 32'd0);
        chk("rst_p1_sum", {31'd0, ifp1.sum}, 32'd0);
        chk("rst_p4", {27'd0, ifp4.out_valid, ifp4.carry, ifp4.sum}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Exhaustive WIDTH=1
        for (int v = 0; v < 8; v++) begin
            {if1.a, if1.b, if1.cin} = 3'(v);
            if1.in_valid = v[0];
            #1;
            chk($sformatf("fa1_%0d", v), {30'd0, if1.carry, if1.sum}, {30'd0, EXP8[v]});
            chk($sformatf("fa1_vld_%0d", v), {31'd0, if1.out_valid}, {31'd0, v[0]});
        end

        // Subtract chain
        ch_a = 4'd4; ch_b = 4'd1; #1;
        chk("sub_4_1", {27'd0, ch_c[4], ch_s}, {27'd0, 1'b1, 4'd3});
        ch_a = 4'd2; ch_b = 4'd5; #1;
        chk("sub_2_5", {27'd0, ch_c[4], ch_s}, {27'd0, 1'b0, 4'd13});

        // WIDTH=4 all-ones boundary
        if4.a = 4'hF; if4.b = 4'hF; if4.cin = 1; #1;
        chk("fa4_max", {27'd0, if4.carry, if4.sum}, {27'd0, 1'b1, 4'hF});
        if4.a = 4'h0; if4.b = 4'h0; if4.cin = 0; #1;
        chk("fa4_zero", {27'd0, if4.carry, if4.sum}, 32'd0);
        if4.a = 4'h8; if4.b = 4'h8; if4.cin = 0; #1;
        chk("fa4_8_8", {27'd0, if4.carry, if4.sum}, {27'd0, 1'b1, 4'h0});
        for (int r = 0; r < 24; r++) begin
            logic [3:0] ra, rb;
            logic       rc;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            if4.a = ra; if4.b = rb; if4.cin = rc; #1;
            chk($sformatf("fa4_rnd_%0d", r), {27'd0, if4.carry, if4.sum},
                32'(ra) + 32'(rb) + 32'(rc));
        end

        // Single pulse through two stages
        @(negedge clk);
        ifp1.a = 1; ifp1.b = 1; ifp1.cin = 0; ifp1.in_valid = 1;
        @(negedge clk);
        chk("pulse_s1_vld", {31'd0, ifp1.out_valid}, 32'd0);
        ifp1.in_valid = 0; ifp1.a = 0; ifp1.b = 0;
        @(negedge clk);
        chk("pulse_s2", {29'd0, ifp1.out_valid, ifp1.carry, ifp1.sum}, {29'd0, 3'b110});
        @(negedge clk);
        chk("pulse_s3_vld", {31'd0, ifp1.out_valid}, 32'd0);

        // Reset one cycle after a pulse flushes it
        ifp1.a = 1; ifp1.b = 1; ifp1.in_valid = 1;
        @(negedge clk);
        ifp1.in_valid = 0; ifp1.a = 0; ifp1.b = 0;
        rst_n = 1'b0;
        #1;
        chk("flush_imm", {29'd0, ifp1.out_valid, ifp1.carry, ifp1.sum}, 32'd0);
        @(negedge clk);
        chk("flush_hold", {29'd0, ifp1.out_valid, ifp1.carry, ifp1.sum}, 32'd0);
        rst_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk($sformatf("flush_after_%0d", w), {31'd0, ifp1.out_valid}, 32'd0);
        end

        // Asynchronous clear of a result already on the outputs
        ifp1.a = 1; ifp1.b = 1; ifp1.in_valid = 1;
        @(negedge clk);
        ifp1.in_valid = 0; ifp1.a = 0; ifp1.b = 0;
        @(negedge clk);
        chk("live_out", {29'd0, ifp1.out_valid, ifp1.carry, ifp1.sum}, {29'd0, 3'b110});
        rst_n = 1'b0;
        #1;
        chk("async_clr", {29'd0, ifp1.out_valid, ifp1.carry, ifp1.sum}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Streaming: 16 back-to-back inputs, results two cycles later
        for (int i = 0; i < 16; i++) begin
            sa[i] = 4'(i * 5 + 3);
            sb[i] = 4'(i * 7 + 1);
            sc[i] = i[0];
        end
        for (int i = 0; i < 19; i++) begin
            if (i >= 2 && i < 18) begin
                chk($sformatf("strm_vld_%0d", i - 2), {31'd0, ifp4.out_valid}, 32'd1);
                chk($sformatf("strm_%0d", i - 2), {27'd0, ifp4.carry, ifp4.sum},
                    32'(sa[i-2]) + 32'(sb[i-2]) + 32'(sc[i-2]));
            end else begin
                chk($sformatf("strm_idle_%0d", i), {31'd0, ifp4.out_valid}, 32'd0);
            end
            if (i < 16) begin
                ifp4.a = sa[i]; ifp4.b = sb[i]; ifp4.cin = sc[i]; ifp4.in_valid = 1;
            end else begin
                ifp4.in_valid = 0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
